phys_free_list: RTL and testbench
=================================

PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and reset.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- alloc_req  in  1  rename stage consumes the head tag this cycle.
- alloc_tag  out  8  head physical tag, show-ahead (combinational from registered state).
- alloc_valid  out  1  free list not empty; alloc_tag usable.
- rel_valid  in  1  release one physical tag.
- rel_tag  in  8  tag being released.
- save_state  in  1  checkpoint the head pointer.
- save_page  in  3  checkpoint slot to write.
- restore_state  in  1  roll the head back.
- restore_page  in  3  checkpoint slot to read.
- free_count  out  9  number of free tags held.
- empty  out  1  free_count == 0.
- overflow_err  out  1  sticky release-while-full error.

Function
REQ-003 SHALL implement a 256-entry circular buffer of 8-bit tags, with 8-bit head and tail pointers and a 9-bit count.
REQ-004 SHALL drive alloc_tag = entry[head] and alloc_valid = 1 when count > 0; when count == 0, alloc_tag = 255 and alloc_valid = 0.
REQ-005 SHALL, on alloc_req && alloc_valid, advance head by 1 mod 256 at the next edge; alloc_req while empty SHALL have no effect.
REQ-006 SHALL, on rel_valid with rel_tag in 1..253, write rel_tag to entry[tail] and advance tail by 1 mod 256.
REQ-007 SHALL ignore releases of tags 0, 254 and 255; these change no state.
REQ-008 SHALL, on a legal release while count == 256, drop the tag and set overflow_err until reset.
REQ-009 SHALL, when alloc and release occur in the same cycle, perform both; count is unchanged.
REQ-010 SHALL NOT bypass a same-cycle release to alloc_tag; a release into an empty list is visible next cycle.
REQ-011 SHALL, on save_state, store into ckpt[save_page] the head value after this cycle's allocation.
REQ-012 SHALL, on restore_state, set head = ckpt[restore_page] and ignore alloc_req that cycle.
REQ-013 SHALL still perform a release on a restore cycle, then set count = (new tail - restored head) mod 256.
REQ-014 SHALL give restore priority over save when both are asserted; the save is dropped.
REQ-015 SHALL rely on the system invariant that at most 222 tags are live between any checkpoint and tail, so rolled-back entries are never overwritten.

Reset
REQ-016 SHALL, on reset, set entry[i] = 32+i for i = 0..221 and all other entries to 0.
REQ-017 SHALL, on reset, set head = 0, tail = 222, count = 222, overflow_err = 0 and every ckpt = 0.
REQ-018 SHALL, after reset, output alloc_tag = 32, alloc_valid = 1, free_count = 222 and empty = 0.
REQ-019 SHALL let reset override every other input in the same cycle, including mid-operation.

Configuration
REQ-020 SHALL, with FREELIST_CKPT_EN defined, implement the eight checkpoint slots and REQ-011 to REQ-014.
REQ-021 SHALL, without FREELIST_CKPT_EN, keep the save/restore ports but ignore them, with no checkpoint storage synthesized.

Structure
REQ-022 SHALL take from shared package rename_pkg: PHYS_TAG_W = 8, NUM_ARCH_REGS = 32, NUM_PHYS_FREE = 222, FL_DEPTH = 256, NUM_CKPT = 8, NO_SRC_TAG = 254 and NO_RD_TAG = 255.
REQ-023 SHALL place the checkpoint storage in sub-module freelist_ckpt_bank (8 x 8-bit head pointers), instantiated only under FREELIST_CKPT_EN.

Verification
REQ-024 Reset, then alloc_req for 3 cycles -> alloc_tag 32, 33, 34 in turn, then 35; free_count = 219.
REQ-025 Allocate 222 times -> empty = 1, alloc_tag = 255; then release tag 40 -> next cycle alloc_tag = 40, free_count = 1.
REQ-026 Same-cycle alloc_req and release of tag 77 -> free_count unchanged; 77 is written at tail.
REQ-027 Release tags 0, 254 and 255 -> no change in free_count or tail.
REQ-028 (FREELIST_CKPT_EN) save to page 2 at head = 5, allocate 4, then restore page 2 with a same-cycle release of 99 -> alloc_tag = 37, count = tail - 5, and 99 is at the old tail.
REQ-029 Assert reset during concurrent alloc/release/restore -> next cycle all values match REQ-018.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared rename-stage constants and types for the physical tag free list
// and its checkpoint bank.
package rename_pkg;

    localparam int PHYS_TAG_W    = 8;
    localparam int NUM_ARCH_REGS = 32;
    localparam int NUM_PHYS_FREE = 222;
    localparam int FL_DEPTH      = 256;
    localparam int NUM_CKPT      = 8;
    localparam int NO_SRC_TAG    = 254;
    localparam int NO_RD_TAG     = 255;

    localparam int FL_PTR_W   = 8;
    localparam int FL_CNT_W   = 9;
    localparam int CKPT_IDX_W = 3;

    typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
    typedef logic [FL_PTR_W-1:0]   fl_ptr_t;
    typedef logic [FL_CNT_W-1:0]   fl_cnt_t;
    typedef logic [CKPT_IDX_W-1:0] ckpt_idx_t;

    // Tag 0 and the two sentinel encodings never enter the free pool.
    function automatic logic is_legal_release(input phys_tag_t tag);
        return (tag != '0) && (int'(tag) < NO_SRC_TAG);
    endfunction

endpackage

// File: rtl/freelist_ckpt_bank.sv
// Eight saved free-list head pointers, written on save and read
// combinationally on restore.
module freelist_ckpt_bank
    import rename_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      save_en,
    input  ckpt_idx_t save_page,
    input  fl_ptr_t   save_head,
    input  ckpt_idx_t restore_page,
    output fl_ptr_t   restore_head
);

    fl_ptr_t ckpt_q [NUM_CKPT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                ckpt_q[i] <= '0;
            end
        end else if (save_en) begin
            ckpt_q[save_page] <= save_head;
        end
    end

    assign restore_head = ckpt_q[restore_page];

endmodule

// File: rtl/phys_free_list.sv
// Circular free list of physical register tags with optional head-pointer
// checkpoints (enabled by defining FREELIST_CKPT_EN).
module phys_free_list
    import rename_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc_req,
    output logic [7:0]      alloc_tag,
    output logic            alloc_valid,
    input  logic            rel_valid,
    input  logic [7:0]      rel_tag,
    input  logic            save_state,
    input  logic [2:0]      save_page,
    input  logic            restore_state,
    input  logic [2:0]      restore_page,
    output logic [8:0]      free_count,
    output logic            empty,
    output logic            overflow_err
);

    // Allocation handshake: alloc_tag is show-ahead and valid whenever
    // alloc_valid is high; a tag is consumed only on a cycle where both
    // alloc_req and alloc_valid are high. Releases have no back-pressure.

    phys_tag_t entry_q [FL_DEPTH];
    fl_ptr_t   head_q;
    fl_ptr_t   tail_q;
    fl_cnt_t   count_q;
    logic      overflow_q;

    logic      has_free;
    logic      full;
    logic      restore_fire;
    fl_ptr_t   ckpt_head;

    logic      alloc_fire;
    logic      rel_legal;
    logic      rel_fire;
    fl_ptr_t   head_alloc;
    fl_ptr_t   head_next;
    fl_ptr_t   tail_next;
    fl_cnt_t   count_next;

    assign has_free = (count_q != '0);
    assign full     = (count_q == FL_CNT_W'(FL_DEPTH));

`ifdef FREELIST_CKPT_EN
    logic save_fire;

    // A restore wins over a save in the same cycle.
    assign restore_fire = restore_state;
    assign save_fire    = save_state && !restore_state;

    freelist_ckpt_bank u_ckpt_bank (
        .clk          (clk),
        .reset        (reset),
        .save_en      (save_fire),
        .save_page    (save_page),
        .save_head    (head_alloc),
        .restore_page (restore_page),
        .restore_head (ckpt_head)
    );
`else
    logic unused_ckpt_ports;

    assign restore_fire      = 1'b0;
    assign ckpt_head         = '0;
    assign unused_ckpt_ports = ^{save_state, save_page, restore_state, restore_page};
`endif

    always_comb begin
        alloc_fire = alloc_req && has_free && !restore_fire;
        rel_legal  = rel_valid && is_legal_release(rel_tag);
        rel_fire   = rel_legal && !full;
        head_alloc = head_q + fl_ptr_t'(alloc_fire);
        tail_next  = tail_q + fl_ptr_t'(rel_fire);
        head_next  = head_alloc;
        count_next = count_q + fl_cnt_t'(rel_fire) - fl_cnt_t'(alloc_fire);
        if (restore_fire) begin
            // Occupancy after a rollback is the ring distance from the
            // restored head to the (possibly just advanced) tail.
            head_next  = ckpt_head;
            count_next = {1'b0, fl_ptr_t'(tail_next - ckpt_head)};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FL_DEPTH; i++) begin
                entry_q[i] <= (i < NUM_PHYS_FREE) ? PHYS_TAG_W'(NUM_ARCH_REGS + i) : '0;
            end
            head_q     <= '0;
            tail_q     <= FL_PTR_W'(NUM_PHYS_FREE);
            count_q    <= FL_CNT_W'(NUM_PHYS_FREE);
            overflow_q <= 1'b0;
        end else begin
            if (rel_fire) begin
                entry_q[tail_q] <= rel_tag;
            end
            head_q  <= head_next;
            tail_q  <= tail_next;
            count_q <= count_next;
            if (rel_legal && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign alloc_tag    = has_free ? entry_q[head_q] : PHYS_TAG_W'(NO_RD_TAG);
    assign alloc_valid  = has_free;
    assign free_count   = count_q;
    assign empty        = !has_free;
    assign overflow_err = overflow_q;

endmodule

// File: tb/tb_phys_free_list.sv
// Self-checking bench for phys_free_list; the checkpoint scenario runs
// when FREELIST_CKPT_EN is defined, otherwise save/restore must be inert.
module tb_phys_free_list;

    logic       clk = 1'b0;
    logic       reset;
    logic       alloc_req;
    logic [7:0] alloc_tag;
    logic       alloc_valid;
    logic       rel_valid;
    logic [7:0] rel_tag;
    logic       save_state;
    logic [2:0] save_page;
    logic       restore_state;
    logic [2:0] restore_page;
    logic [8:0] free_count;
    logic       empty;
    logic       overflow_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp_tag;

    phys_free_list dut (
        .clk           (clk),
        .reset         (reset),
        .alloc_req     (alloc_req),
        .alloc_tag     (alloc_tag),
        .alloc_valid   (alloc_valid),
        .rel_valid     (rel_valid),
        .rel_tag       (rel_tag),
        .save_state    (save_state),
        .save_page     (save_page),
        .restore_state (restore_state),
        .restore_page  (restore_page),
        .free_count    (free_count),
        .empty         (empty),
        .overflow_err  (overflow_err)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_req     = 1'b0;
        rel_valid     = 1'b0;
        rel_tag       = 8'd0;
        save_state    = 1'b0;
        save_page     = 3'd0;
        restore_state = 1'b0;
        restore_page  = 3'd0;
    endtask

    task automatic drive_alloc();
        alloc_req = 1'b1;
        tick();
        alloc_req = 1'b0;
    endtask

    task automatic drive_release(input logic [7:0] tag);
        rel_valid = 1'b1;
        rel_tag   = tag;
        tick();
        rel_valid = 1'b0;
        rel_tag   = 8'd0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 32; i <= 253; i++) exp_q.push_back(8'(i));
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        tests_run++;
        if (alloc_tag !== 8'd32) begin
            tests_failed++; $display("FAIL reset_alloc_tag: got %0d expected 32", alloc_tag);
        end
        tests_run++;
        if (alloc_valid !== 1'b1) begin
            tests_failed++; $display("FAIL reset_alloc_valid: got %0b expected 1", alloc_valid);
        end
        tests_run++;
        if (free_count !== 9'd222) begin
            tests_failed++; $display("FAIL reset_free_count: got %0d expected 222", free_count);
        end
        tests_run++;
        if (empty !== 1'b0 || overflow_err !== 1'b0) begin
            tests_failed++; $display("FAIL reset_flags: got empty=%0b ovf=%0b expected 0 0", empty, overflow_err);
        end
    endtask

    task automatic test_alloc_seq();
        for (int i = 0; i < 3; i++) begin
            exp_tag = exp_q.pop_front();
            tests_run++;
            if (alloc_tag !== exp_tag) begin
                tests_failed++; $display("FAIL alloc_seq_tag: got %0d expected %0d", alloc_tag, exp_tag);
            end
            drive_alloc();
        end
        tests_run++;
        if (alloc_tag !== exp_q[0]) begin
            tests_failed++; $display("FAIL alloc_seq_next: got %0d expected %0d", alloc_tag, exp_q[0]);
        end
        tests_run++;
        if (free_count !== 9'(exp_q.size())) begin
            tests_failed++; $display("FAIL alloc_seq_count: got %0d expected %0d", free_count, exp_q.size());
        end
    endtask

    task automatic test_drain_release();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            exp_tag = exp_q.pop_front();
            tests_run++;
            if (alloc_tag !== exp_tag) begin
                tests_failed++; $display("FAIL drain_tag: got %0d expected %0d", alloc_tag, exp_tag);
            end
            drive_alloc();
        end
        tests_run++;
        if (empty !== 1'b1 || alloc_valid !== 1'b0 || alloc_tag !== 8'd255 || free_count !== 9'd0) begin
            tests_failed++;
            $display("FAIL drain_empty: got empty=%0b valid=%0b tag=%0d count=%0d expected 1 0 255 0",
                     empty, alloc_valid, alloc_tag, free_count);
        end
        drive_alloc();
        tests_run++;
        if (free_count !== 9'd0 || alloc_tag !== 8'd255) begin
            tests_failed++; $display("FAIL alloc_when_empty: got count=%0d tag=%0d expected 0 255", free_count, alloc_tag);
        end
        rel_valid = 1'b1;
        rel_tag   = 8'd40;
        #1;
        tests_run++;
        if (alloc_tag !== 8'd255) begin
            tests_failed++; $display("FAIL no_bypass: got %0d expected 255", alloc_tag);
        end
        tick();
        rel_valid = 1'b0;
        exp_q.push_back(8'd40);
        tests_run++;
        if (alloc_tag !== exp_q[0] || free_count !== 9'(exp_q.size())) begin
            tests_failed++; $display("FAIL release_into_empty: got tag=%0d count=%0d expected %0d %0d",
                                     alloc_tag, free_count, exp_q[0], exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 10; t <= 12; t++) begin
            drive_release(8'(t));
            exp_q.push_back(8'(t));
        end
        exp_tag = exp_q.pop_front();
        tests_run++;
        if (alloc_tag !== exp_tag) begin
            tests_failed++; $display("FAIL same_cycle_tag: got %0d expected %0d", alloc_tag, exp_tag);
        end
        alloc_req = 1'b1;
        rel_valid = 1'b1;
        rel_tag   = 8'd77;
        tick();
        idle_inputs();
        exp_q.push_back(8'd77);
        tests_run++;
        if (free_count !== 9'(exp_q.size())) begin
            tests_failed++; $display("FAIL same_cycle_count: got %0d expected %0d", free_count, exp_q.size());
        end
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            exp_tag = exp_q.pop_front();
            tests_run++;
            if (alloc_tag !== exp_tag) begin
                tests_failed++; $display("FAIL same_cycle_drain: got %0d expected %0d", alloc_tag, exp_tag);
            end
            drive_alloc();
        end
    endtask

    task automatic test_illegal_release();
        logic [7:0] bad_tags [3];
        bad_tags[0] = 8'd0;
        bad_tags[1] = 8'd254;
        bad_tags[2] = 8'd255;
        for (int i = 0; i < 3; i++) begin
            drive_release(bad_tags[i]);
            tests_run++;
            if (free_count !== 9'd0 || empty !== 1'b1) begin
                tests_failed++; $display("FAIL illegal_release_%0d: got count=%0d expected 0", bad_tags[i], free_count);
            end
        end
        drive_release(8'd5);
        drive_release(8'd1);
        drive_release(8'd253);
        exp_q.push_back(8'd5);
        exp_q.push_back(8'd1);
        exp_q.push_back(8'd253);
        tests_run++;
        if (free_count !== 9'(exp_q.size())) begin
            tests_failed++; $display("FAIL legal_bounds_count: got %0d expected %0d", free_count, exp_q.size());
        end
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            exp_tag = exp_q.pop_front();
            tests_run++;
            if (alloc_tag !== exp_tag) begin
                tests_failed++; $display("FAIL illegal_tail_order: got %0d expected %0d", alloc_tag, exp_tag);
            end
            drive_alloc();
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int t = 100; t < 134; t++) begin
            drive_release(8'(t));
            exp_q.push_back(8'(t));
        end
        tests_run++;
        if (free_count !== 9'd256 || overflow_err !== 1'b0) begin
            tests_failed++; $display("FAIL full_count: got count=%0d ovf=%0b expected 256 0", free_count, overflow_err);
        end
        drive_release(8'd200);
        tests_run++;
        if (free_count !== 9'd256 || overflow_err !== 1'b1) begin
            tests_failed++; $display("FAIL overflow_set: got count=%0d ovf=%0b expected 256 1", free_count, overflow_err);
        end
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            exp_tag = exp_q.pop_front();
            tests_run++;
            if (alloc_tag !== exp_tag) begin
                tests_failed++; $display("FAIL overflow_drain: got %0d expected %0d", alloc_tag, exp_tag);
            end
            drive_alloc();
        end
        tests_run++;
        if (empty !== 1'b1 || overflow_err !== 1'b1) begin
            tests_failed++; $display("FAIL overflow_sticky: got empty=%0b ovf=%0b expected 1 1", empty, overflow_err);
        end
        apply_reset();
        tests_run++;
        if (overflow_err !== 1'b0) begin
            tests_failed++; $display("FAIL overflow_clear: got %0b expected 0", overflow_err);
        end
    endtask

`ifdef FREELIST_CKPT_EN
    task automatic test_ckpt();
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            exp_tag = exp_q.pop_front();
            tests_run++;
            if (alloc_tag !== exp_tag) begin
                tests_failed++; $display("FAIL ckpt_alloc: got %0d expected %0d", alloc_tag, exp_tag);
            end
            // Save page 2 on the fifth allocation: checkpointed head is 5.
            if (i == 4) begin
                save_state = 1'b1;
                save_page  = 3'd2;
            end
            drive_alloc();
            save_state = 1'b0;
        end
        restore_state = 1'b1;
        restore_page  = 3'd2;
        save_state    = 1'b1;
        save_page     = 3'd2;
        alloc_req     = 1'b1;
        rel_valid     = 1'b1;
        rel_tag       = 8'd99;
        tick();
        idle_inputs();
        exp_q.delete();
        for (int i = 37; i <= 253; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'd99);
        tests_run++;
        if (alloc_tag !== 8'd37 || free_count !== 9'(exp_q.size())) begin
            tests_failed++; $display("FAIL ckpt_restore: got tag=%0d count=%0d expected 37 %0d",
                                     alloc_tag, free_count, exp_q.size());
        end
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) begin
            exp_tag = exp_q.pop_front();
            tests_run++;
            if (alloc_tag !== exp_tag) begin
                tests_failed++; $display("FAIL ckpt_drain: got %0d expected %0d", alloc_tag, exp_tag);
            end
            drive_alloc();
        end
        restore_state = 1'b1;
        restore_page  = 3'd2;
        tick();
        idle_inputs();
        tests_run++;
        if (alloc_tag !== 8'd37 || free_count !== 9'd218) begin
            tests_failed++; $display("FAIL ckpt_save_dropped: got tag=%0d count=%0d expected 37 218", alloc_tag, free_count);
        end
        restore_state = 1'b1;
        restore_page  = 3'd0;
        tick();
        idle_inputs();
        tests_run++;
        if (alloc_tag !== 8'd32 || free_count !== 9'd223) begin
            tests_failed++; $display("FAIL ckpt_page0: got tag=%0d count=%0d expected 32 223", alloc_tag, free_count);
        end
    endtask
`else
    task automatic test_ckpt_ignored();
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            exp_tag = exp_q.pop_front();
            tests_run++;
            if (alloc_tag !== exp_tag) begin
                tests_failed++; $display("FAIL nockpt_alloc: got %0d expected %0d", alloc_tag, exp_tag);
            end
            save_state    = (i == 2);
            save_page     = 3'd2;
            restore_state = (i == 5);
            restore_page  = 3'd2;
            drive_alloc();
            idle_inputs();
        end
        tests_run++;
        if (alloc_tag !== exp_q[0] || free_count !== 9'(exp_q.size())) begin
            tests_failed++; $display("FAIL nockpt_restore_ignored: got tag=%0d count=%0d expected %0d %0d",
                                     alloc_tag, free_count, exp_q[0], exp_q.size());
        end
    endtask
`endif

    task automatic test_reset_midop();
        drive_alloc();
        drive_alloc();
        reset         = 1'b1;
        alloc_req     = 1'b1;
        rel_valid     = 1'b1;
        rel_tag       = 8'd99;
        save_state    = 1'b1;
        save_page     = 3'd1;
        restore_state = 1'b1;
        restore_page  = 3'd1;
        tick();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        tests_run++;
        if (alloc_tag !== 8'd32 || alloc_valid !== 1'b1 || free_count !== 9'd222 || empty !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_midop: got tag=%0d valid=%0b count=%0d empty=%0b expected 32 1 222 0",
                     alloc_tag, alloc_valid, free_count, empty);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_alloc_seq();
        test_drain_release();
        test_back_to_back();
        test_illegal_release();
        test_overflow();
`ifdef FREELIST_CKPT_EN
        test_ckpt();
`else
        test_ckpt_ignored();
`endif
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
